ysyx_24080014_wb_arbiter: RTL

//  Writeback arbiter and sequencer for the GPR/CSR register file write port.

---
 rtl/ysyx_24080014_wb_pkg.sv | 33 +++
 rtl/ysyx_24080014_wb_scoreboard.sv | 39 +++
 rtl/ysyx_24080014_wb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ysyx_24080014_wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// The optional scoreboard is enabled with WB_ARB_SCOREBOARD_EN.
package ysyx_24080014_wb_pkg;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_ECALL = 2'b01,
        CSR_MRET  = 2'b10,
        CSR_RSVD  = 2'b11
    } csr_ctl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_HOLD
    } wb_state_e;

    localparam logic [11:0] CSR_ADDR_NONE    = 12'h000;
    localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;

    function automatic logic is_trap(input logic [1:0] ctl);
        return (ctl == CSR_ECALL) || (ctl == CSR_MRET);
    endfunction

    // The reserved encoding behaves exactly like "no CSR action".
    function automatic logic [1:0] clean_ctl(input logic [1:0] ctl);
        return (ctl == CSR_RSVD) ? CSR_NONE : ctl;
    endfunction

endpackage

// File: rtl/ysyx_24080014_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR x1..x31.
// Only instantiated when WB_ARB_SCOREBOARD_EN is defined.
module ysyx_24080014_wb_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc,
    input  logic [4:0] alloc_rd,
    input  logic       clr,
    input  logic [4:0] clr_rd,
    input  logic       flush,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hazard
);

    logic [31:1] busy;
    logic [31:1] busy_next;
    logic [31:0] busy_all;

    // NOTE: every bit of busy_next gets a value on every path, so no latch is inferred.
    always_comb begin
        busy_next = '0;
        for (int i = 1; i < 32; i++) begin
            // A same-cycle allocation beats both the write-back clear and a trap flush.
            busy_next[i] = (alloc && alloc_rd == 5'(i))
                         | (!flush && busy[i] && !(clr && clr_rd == 5'(i)));
        end
    end

    // NOTE: the busy vector is plain flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

    assign busy_all = {busy, 1'b0};
    assign hazard   = busy_all[rs1] | busy_all[rs2];

endmodule

// File: rtl/ysyx_24080014_wb_arbiter.sv
// Round-robin writeback arbiter between EXU and LSU with a post-trap hold window.
// Define WB_ARB_SCOREBOARD_EN to add the pending-write scoreboard and its ports.
module ysyx_24080014_wb_arbiter
    import ysyx_24080014_wb_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned TRAP_HOLD_CYC = 2,
    parameter bit          RR_INIT       = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic [1:0]      ex_csr_ctl,
    input  logic [11:0]     ex_csr_waddr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ls_valid,
    output logic            ls_ready,
    input  logic [4:0]      ls_rd,
    input  logic [XLEN-1:0] ls_data,
    output logic            RegWr,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [1:0]      wb_csr_ctl,
    output logic [11:0]     wb_csr_waddr,
    output logic [XLEN-1:0] wb_pc,
    output logic            trap_flush
`ifdef WB_ARB_SCOREBOARD_EN
    ,
    input  logic            sb_alloc,
    input  logic [4:0]      sb_alloc_rd,
    input  logic [4:0]      sb_rs1,
    input  logic [4:0]      sb_rs2,
    output logic            sb_hazard
`endif
);

    localparam int HW = (TRAP_HOLD_CYC > 1) ? $clog2(TRAP_HOLD_CYC) : 1;

    wb_state_e   state;
    logic        rr_lsu;      // 1: LSU wins the next two-way contest
    logic [HW-1:0] hold_cnt;
    logic        grant_ls;
    logic        open;
    logic        ex_trap;

    assign grant_ls = ls_valid & (~ex_valid | rr_lsu);
    assign open     = rst_n & (state != ST_HOLD);
    assign ex_ready = open & ex_valid & ~grant_ls;
    assign ls_ready = open & grant_ls;
    assign ex_trap  = is_trap(ex_csr_ctl);

    // NOTE: state and output registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_lsu       <= RR_INIT;
            hold_cnt     <= '0;
            RegWr        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_csr_ctl   <= CSR_NONE;
            wb_csr_waddr <= CSR_ADDR_NONE;
            wb_pc        <= '0;
            trap_flush   <= 1'b0;
        end else begin
            RegWr      <= ex_ready | ls_ready;
            trap_flush <= ex_ready & ex_trap;

            if (ex_ready) begin
                wb_rd        <= ex_rd;
                wb_data      <= ex_data;
                wb_csr_ctl   <= clean_ctl(ex_csr_ctl);
                wb_csr_waddr <= ex_csr_waddr;
                wb_pc        <= ex_pc;
                rr_lsu       <= 1'b1;
            end else if (ls_ready) begin
                wb_rd        <= ls_rd;
                wb_data      <= ls_data;
                wb_csr_ctl   <= CSR_NONE;
                wb_csr_waddr <= CSR_ADDR_NONE;
                wb_pc        <= '0;
                rr_lsu       <= 1'b0;
            end

            // The trap beat's own write cycle is the first of the hold cycles.
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == '0) state    <= ST_IDLE;
                    else                hold_cnt <= hold_cnt - 1'b1;
                end
                default: begin
                    if (ex_ready && ex_trap) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HW'(TRAP_HOLD_CYC - 1);
                    end else if (ex_ready || ls_ready) begin
                        state <= ST_WB;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef WB_ARB_SCOREBOARD_EN
    ysyx_24080014_wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc    (sb_alloc),
        .alloc_rd (sb_alloc_rd),
        .clr      (RegWr),
        .clr_rd   (wb_rd),
        .flush    (trap_flush),
        .rs1      (sb_rs1),
        .rs2      (sb_rs2),
        .hazard   (sb_hazard)
    );
`endif

endmodule
